// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction producer for the control decoder. It walks sequential PCs,
// issues requests to a synchronous instruction memory, buffers the returned
// words together with their PCs in a small FIFO, and hands the head entry to
// decode through a valid/ready handshake. A redirect from downstream flushes
// the FIFO, drops the fetch in flight and restarts fetching at the target.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   DEPTH          FIFO entries (power of two, >= 2)
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rstn           synchronous active-low reset
//   imem_req       fetch request this cycle
//   imem_addr      fetch address (word aligned), always the current fetch PC
//   imem_rdata     instruction word, valid one cycle after its request
//   redirect_valid flush the queue and restart fetch
//   redirect_pc    restart address, low two bits ignored
//   out_valid      head entry available to decode
//   out_ready      decode accepts the head entry
//   out_pc         PC of the head entry
//   out_instr      head instruction, NOP (32'h0000_0013) when out_valid=0
//   out_opcode     out_instr[6:0]
//   count          current FIFO occupancy
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic [31:0]                imem_rdata,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   output logic [6:0]                 out_opcode,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic          inflight;
   logic [31:0]   inflight_pc;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [31:0]   mem_pc    [DEPTH];
   logic [31:0]   mem_instr [DEPTH];

   logic [AW+1:0] pending;
   logic          issue;
   logic          push;
   logic          pop;

   // Occupancy plus the word still coming back from memory. A same-cycle
   // dequeue is deliberately not credited, so a response always has a slot.
   assign pending   = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
   assign issue     = rstn && !redirect_valid && (pending < DEPTH_L);
   assign push      = rstn && inflight && !redirect_valid;
   assign pop       = rstn && out_valid && out_ready && !redirect_valid;

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   // Decode only ever sees FIFO state, never imem_rdata directly.
   assign out_valid  = (count != '0);
   assign out_pc     = mem_pc[head];
   assign out_instr  = out_valid ? mem_instr[head] : NOP;
   assign out_opcode = out_instr[6:0];

   // Fetch PC, in-flight tracking, pointers and occupancy. A redirect wins
   // over every other update, which also makes back-to-back redirects resolve
   // to the last one.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
         inflight    <= 1'b0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
      end else begin
         if (issue) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
         end else begin
            inflight    <= 1'b0;
         end
         if (push) begin
            tail <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage needs no reset; occupancy and pointers define what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[tail]    <= inflight_pc;
         mem_instr[tail] <= imem_rdata;
      end
   end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction producer that feeds the main control decoder: generates sequential PCs, issues requests to a synchronous instruction memory, buffers returned words in a FIFO, and presents them (with the opcode field split out) to decode through a valid/ready handshake. Branch and jump outcomes resolved downstream return as a redirect that flushes the queue, discards the in-flight fetch and restarts fetch at the target PC. It sits between instruction memory and the decode/control stage.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  synchronous, active-low reset
- imem_req  output  1  fetch request this cycle
- imem_addr  output  32  fetch address (word aligned)
- imem_rdata  input  32  instruction word; valid exactly one cycle after the imem_req cycle
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  restart address; bits [1:0] ignored (forced to 00)
- out_valid  output  1  head entry available
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of head entry
- out_instr  output  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0
- out_opcode  output  7  out_instr[6:0]
- count  output  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- State: fetch_pc (32), inflight (1), inflight_pc (32), FIFO of {pc, instr} with head/tail pointers and count.
- Reset (rstn=0 at an edge): fetch_pc=RESET_PC, inflight=0, count=0, pointers=0. Outputs during/after reset: imem_req=0 while rstn=0, out_valid=0, out_instr=NOP, out_opcode=7'h13, count=0. Reset mid-operation discards all entries and any in-flight response.
- Issue: imem_req=1 when rstn=1, redirect_valid=0 and count + inflight < DEPTH (dequeue in the same cycle is not credited). imem_addr=fetch_pc always; on issue fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0), inflight ← 1, inflight_pc ← fetch_pc; otherwise inflight ← 0.
- Response: in a cycle where inflight=1 and redirect_valid=0, {inflight_pc, imem_rdata} is written at the tail; never dropped (issue rule guarantees space).
- Dequeue: out_valid=1 iff count>0; head popped on out_valid & out_ready & !redirect_valid. Simultaneous push and pop: count unchanged.
- Redirect (redirect_valid=1 in cycle N): no dequeue, no enqueue, response arriving in N discarded, imem_req=0 in N; at edge: count=0, pointers=0, inflight=0, fetch_pc={redirect_pc[31:2],2'b00}. Fetch resumes at N+1. Back-to-back redirects: last one wins.
- FIFO order strictly preserved; out_pc/out_instr stable while out_valid=1 and out_ready=0.

## Timing
- Reset release: first req at cycle 0 (first cycle with rstn=1), addr RESET_PC; data cycle 1; out_valid=1 from cycle 2.
- Redirect in N: req to target in N+1, out_valid=1 with target in N+3 at earliest; out_valid=0 in N+1 and N+2.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs +4.
- out_ready=0 held: exactly DEPTH entries fill, imem_req drops to 0 once count + inflight = DEPTH; no overflow, no lost words.
- Outputs registered/derived from FIFO head only; no combinational path from imem_rdata to out_*.

## Test plan
- Reset then out_ready=1, memory returns word = addr: imem_addr 0,4,8,... from cycle 0; out_valid rises cycle 2; out_pc 0,4,8 with out_instr matching; count never exceeds 2.
- out_ready=0 for 10 cycles after reset: count saturates at 4, imem_req=0 after 4 issues, out_pc stays 0; then out_ready=1 drains 0,4,8,12 then 16 onward without gaps or duplicates.
- redirect_valid=1, redirect_pc=0x0000_0103 with queue full and a fetch in flight: count=0 next cycle, out_valid=0 and out_instr=32'h13 for two cycles, next imem_addr=0x100, first out_pc=0x100.
- Redirect simultaneous with out_ready=1 and a returning response: head not consumed, response discarded, nothing from old stream ever appears after the redirect.
- fetch_pc wrap: RESET_PC=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
- rstn=0 asserted for one cycle mid-stream with count=3: next cycle count=0, out_valid=0, first post-reset imem_addr=RESET_PC.
